// File: rtl/lc3_mem_unit.sv
// LC-3 memory unit: MAR/MDR, word-addressed array and a wait-state R handshake.
// Define LC3_MMIO_EN to add keyboard/display registers at 0xFE00-0xFE06.
module lc3_mem_unit #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [DATA_W-1:0] i_bus,
    input  logic              i_ld_mar,
    input  logic              i_ld_mdr,
    input  logic              i_mio_en,
    input  logic              i_r_w,
`ifdef LC3_MMIO_EN
    input  logic              i_kbd_valid,
    input  logic [7:0]        i_kbd_char,
    input  logic              i_disp_ready,
    output logic              o_disp_valid,
    output logic [7:0]        o_disp_char,
`endif
    output logic              o_r,
    output logic [DATA_W-1:0] o_mar_out,
    output logic [DATA_W-1:0] o_mdr_out,
    output logic              o_busy
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_op;
    logic              r_r;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req_mmio;
    logic              w_acc_mmio;
    logic              w_mem_we;
    logic              w_mdr_rd;
    logic              w_mdr_bus;
    logic              w_r_nxt;
    logic              w_busy_nxt;
    logic [DATA_W-1:0] w_rd_val;

`ifdef LC3_MMIO_EN
    localparam logic [15:0] MMIO_BASE = 16'hFE00;

    logic              r_mmio;
    logic [1:0]        r_mmio_sel;
    logic              r_kb_rdy;
    logic [7:0]        r_kb_buf;
    logic              r_disp_valid;
    logic [7:0]        r_disp_char;
    logic              w_kb_clr;
    logic              w_disp_valid_nxt;
    logic [DATA_W-1:0] w_mmio_rdata;

    // Even addresses 0xFE00..0xFE06 of the full 16-bit MAR
    assign w_req_mmio = (r_mar[15:3] == MMIO_BASE[15:3]) && !r_mar[0];
    assign w_acc_mmio = r_mmio;
`else
    assign w_req_mmio = 1'b0;
    assign w_acc_mmio = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping MIO_EN before DONE aborts the access
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_mio_en) begin
                    w_state_nxt = (w_req_mmio || (WAIT_CYCLES == 0)) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_mio_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = i_mio_en ? S_DONE : S_IDLE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode
    always_comb begin
        w_r_nxt    = 1'b0;
        w_busy_nxt = 1'b0;
        w_mem_we   = 1'b0;
        w_mdr_rd   = 1'b0;
        w_mdr_bus  = 1'b0;
        w_r_nxt    = (w_state_nxt == S_DONE);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_mem_we   = i_rstn && (r_state == S_ACCESS) && i_mio_en && r_op && !w_acc_mmio;
        w_mdr_rd   = (r_state == S_DONE) && !r_op && i_ld_mdr;
        w_mdr_bus  = i_ld_mdr && !i_mio_en;
`ifdef LC3_MMIO_EN
        w_kb_clr         = 1'b0;
        w_disp_valid_nxt = 1'b0;
        w_kb_clr         = w_mdr_rd && r_mmio && (r_mmio_sel == 2'd1);
        w_disp_valid_nxt = (r_state == S_ACCESS) && (w_state_nxt == S_DONE)
                           && r_mmio && r_op && (r_mmio_sel == 2'd3);
`endif
    end

    // Registered handshake outputs track the state being entered
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_r    <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_r    <= w_r_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // MAR, MDR and the per-access latches
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_mar   <= '0;
            r_mdr   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_op    <= 1'b0;
            r_wdata <= '0;
        end else begin
            if (i_ld_mar) begin
                r_mar <= i_bus;
            end
            if (w_mdr_rd) begin
                r_mdr <= r_rdata;
            end else if (w_mdr_bus) begin
                r_mdr <= i_bus;
            end
            if ((r_state == S_IDLE) && i_mio_en) begin
                r_addr  <= r_mar[ADDR_W-1:0];
                r_op    <= i_r_w;
                r_wdata <= r_mdr;
                r_cnt   <= CNT_W'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Read data source for the ACCESS cycle
    always_comb begin
        w_rd_val = r_mem[r_addr];
`ifdef LC3_MMIO_EN
        if (r_mmio) begin
            w_rd_val = w_mmio_rdata;
        end
`endif
    end

    // Memory array; contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
        if (r_state == S_ACCESS) begin
            r_rdata <= w_rd_val;
        end
    end

`ifdef LC3_MMIO_EN
    always_comb begin
        w_mmio_rdata = '0;
        case (r_mmio_sel)
            2'd0:    w_mmio_rdata = DATA_W'({r_kb_rdy, 15'b0});
            2'd1:    w_mmio_rdata = DATA_W'({8'b0, r_kb_buf});
            2'd2:    w_mmio_rdata = DATA_W'({i_disp_ready, 15'b0});
            default: w_mmio_rdata = '0;
        endcase
    end

    // Keyboard capture: a KBDR read clear takes priority over a new char
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_mmio       <= 1'b0;
            r_mmio_sel   <= 2'd0;
            r_kb_rdy     <= 1'b0;
            r_kb_buf     <= 8'd0;
            r_disp_valid <= 1'b0;
            r_disp_char  <= 8'd0;
        end else begin
            if ((r_state == S_IDLE) && i_mio_en) begin
                r_mmio     <= w_req_mmio;
                r_mmio_sel <= r_mar[2:1];
            end
            if (w_kb_clr) begin
                r_kb_rdy <= 1'b0;
            end else if (i_kbd_valid && !r_kb_rdy) begin
                r_kb_rdy <= 1'b1;
                r_kb_buf <= i_kbd_char;
            end
            r_disp_valid <= w_disp_valid_nxt;
            if (w_disp_valid_nxt) begin
                r_disp_char <= r_wdata[7:0];
            end
        end
    end

    assign o_disp_valid = r_disp_valid;
    assign o_disp_char  = r_disp_char;
`endif

    assign o_r       = r_r;
    assign o_busy    = r_busy;
    assign o_mar_out = r_mar;
    assign o_mdr_out = r_mdr;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Self-checking bench for lc3_mem_unit (ADDR_W=8, WAIT_CYCLES=2).
// Build with LC3_MMIO_EN defined to also exercise keyboard/display registers.
module tb_lc3_mem_unit;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int          WAITC  = 2;
    localparam int          NV     = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio_en, r_w;
    logic        o_r, o_busy;
    logic [15:0] o_mar_out, o_mdr_out;
`ifdef LC3_MMIO_EN
    logic        kbd_valid, disp_ready, o_disp_valid;
    logic [7:0]  kbd_char, o_disp_char;
    int          dv_at_r = 0;
    int          dv_outside = 0;
`endif

    always #5 clk = ~clk;

    lc3_mem_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_bus       (bus),
        .i_ld_mar    (ld_mar),
        .i_ld_mdr    (ld_mdr),
        .i_mio_en    (mio_en),
        .i_r_w       (r_w),
`ifdef LC3_MMIO_EN
        .i_kbd_valid (kbd_valid),
        .i_kbd_char  (kbd_char),
        .i_disp_ready(disp_ready),
        .o_disp_valid(o_disp_valid),
        .o_disp_char (o_disp_char),
`endif
        .o_r         (o_r),
        .o_mar_out   (o_mar_out),
        .o_mdr_out   (o_mdr_out),
        .o_busy      (o_busy)
    );

`ifdef LC3_MMIO_EN
    always @(negedge clk) begin
        if (o_disp_valid && o_r)  dv_at_r++;
        if (o_disp_valid && !o_r) dv_outside++;
    end
`endif

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[NV];
    logic [15:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n, k;
    bit          seen, rseen;
    logic [15:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load_mar(input logic [15:0] v);
        bus = v; ld_mar = 1'b1;
        @(negedge clk);
        ld_mar = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        bus = v; ld_mdr = 1'b1;
        @(negedge clk);
        ld_mdr = 1'b0;
    endtask

    // Counts edges until R is seen at a falling edge, bounded
    task automatic wait_r(output int cnt, output bit got);
        cnt = 0; got = 1'b0;
        while (!got && cnt < 40) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            got = o_r;
        end
    endtask

    // One full access; for reads val is the expected data, for writes the data
    task automatic access(input logic [15:0] addr, input logic wr, input logic [15:0] val,
                          input int exp_lat, input string name);
        int          cnt;
        bit          got;
        logic [15:0] mdr_before;
        logic [15:0] ex;
        load_mar(addr);
        if (wr) load_mdr(val);
        else    sb_q.push_back(val);
        mdr_before = o_mdr_out;
        mio_en = 1'b1; r_w = wr; ld_mdr = !wr; bus = 16'hA5A5;
        wait_r(cnt, got);
        chk({name, " R seen"}, 32'(got), 32'd1);
        chk({name, " latency"}, cnt, exp_lat);
        if (!wr) chk({name, " mdr hold"}, o_mdr_out, mdr_before);
        @(posedge clk); @(negedge clk);
        mio_en = 1'b0; ld_mdr = 1'b0; r_w = 1'b0;
        chk({name, " R pulse"}, o_r, 0);
        chk({name, " busy idle"}, o_busy, 0);
        if (!wr) begin
            ex = sb_q.pop_front();
            chk({name, " rdata"}, o_mdr_out, ex);
        end
    endtask

    initial begin
        vecs[0] = '{16'h3000, 1'b1, 16'hBEEF, 16'h0000};
        vecs[1] = '{16'h3000, 1'b0, 16'h0000, 16'hBEEF};
        vecs[2] = '{16'h0010, 1'b1, 16'h5A5A, 16'h0000};
        vecs[3] = '{16'h3001, 1'b1, 16'h0000, 16'h0000};
        vecs[4] = '{16'h0105, 1'b1, 16'hC0DE, 16'h0000};
        vecs[5] = '{16'h0005, 1'b0, 16'h0000, 16'hC0DE};
        vecs[6] = '{16'h00FF, 1'b1, 16'h1111, 16'h0000};
        vecs[7] = '{16'hFFFF, 1'b0, 16'h0000, 16'h1111};
        vecs[8] = '{16'h0042, 1'b1, 16'hFFFF, 16'h0000};
        vecs[9] = '{16'h0010, 1'b0, 16'h0000, 16'h5A5A};

        rstn = 1'b0; bus = '0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
`ifdef LC3_MMIO_EN
        kbd_valid = 1'b0; kbd_char = 8'd0; disp_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst mar", o_mar_out, 0);
        chk("rst mdr", o_mdr_out, 0);
        chk("rst r", o_r, 0);
        chk("rst busy", o_busy, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            access(vecs[i].addr, vecs[i].wr, vecs[i].wr ? vecs[i].wdata : vecs[i].exp,
                   WAITC + 2, $sformatf("vec%0d", i));
        end

        // Reset after register loads keeps memory
        load_mar(16'h1234);
        load_mdr(16'h5678);
        chk("pre-rst mar", o_mar_out, 16'h1234);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("rst2 mar", o_mar_out, 0);
        chk("rst2 mdr", o_mdr_out, 0);
        chk("rst2 r", o_r, 0);
        chk("rst2 busy", o_busy, 0);
        access(16'h0010, 1'b0, 16'h5A5A, WAITC + 2, "post-rst read");

        // Reset in ACCESS drops the pending write
        load_mar(16'h0042);
        load_mdr(16'hDEAD);
        mio_en = 1'b1; r_w = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("rst-acc busy", o_busy, 1);
        rstn = 1'b0;
        @(posedge clk); @(negedge clk);
        rstn = 1'b1; mio_en = 1'b0; r_w = 1'b0;
        chk("rst-acc busy after", o_busy, 0);
        chk("rst-acc r", o_r, 0);
        access(16'h0042, 1'b0, 16'hFFFF, WAITC + 2, "rst-acc readback");

        // Abort in WAIT
        load_mar(16'h3001);
        load_mdr(16'h1234);
        mio_en = 1'b1; r_w = 1'b1;
        @(posedge clk); @(negedge clk);
        mio_en = 1'b0;
        rseen = 1'b0;
        repeat (8) begin @(posedge clk); @(negedge clk); if (o_r) rseen = 1'b1; end
        chk("abort-wait no R", 32'(rseen), 0);
        chk("abort-wait busy", o_busy, 0);
        chk("abort-wait mdr", o_mdr_out, 16'h1234);
        access(16'h3001, 1'b0, 16'h0000, WAITC + 2, "abort-wait readback");

        // Abort in ACCESS
        load_mar(16'h3001);
        load_mdr(16'h4321);
        mio_en = 1'b1; r_w = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        mio_en = 1'b0;
        rseen = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); if (o_r) rseen = 1'b1; end
        chk("abort-acc no R", 32'(rseen), 0);
        access(16'h3001, 1'b0, 16'h0000, WAITC + 2, "abort-acc readback");

        // Back-to-back reads with aliasing, MAR reloaded during DONE
        load_mar(16'h0105);
        sb_q.push_back(16'hC0DE);
        sb_q.push_back(16'hC0DE);
        mio_en = 1'b1; r_w = 1'b0; ld_mdr = 1'b1; bus = 16'hA5A5;
        wait_r(n, seen);
        chk("b2b first latency", n, WAITC + 2);
        bus = 16'h0005; ld_mar = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 1) begin
                ld_mar = 1'b0; bus = 16'hA5A5;
                e = sb_q.pop_front();
                chk("b2b first rdata", o_mdr_out, e);
                chk("b2b idle R", o_r, 0);
            end
            seen = o_r;
        end
        chk("b2b gap", k, WAITC + 3);
        @(posedge clk); @(negedge clk);
        mio_en = 1'b0; ld_mdr = 1'b0;
        e = sb_q.pop_front();
        chk("b2b second rdata", o_mdr_out, e);
        chk("b2b mar", o_mar_out, 16'h0005);

        // R_W and MAR changes mid-access do not affect the latched access
        load_mar(16'h0010);
        sb_q.push_back(16'h5A5A);
        mio_en = 1'b1; r_w = 1'b0; ld_mdr = 1'b1; bus = 16'hA5A5;
        @(posedge clk); @(negedge clk);
        r_w = 1'b1; bus = 16'h0042; ld_mar = 1'b1;
        wait_r(n, seen);
        chk("rw-chg latency", n, WAITC + 1);
        ld_mar = 1'b0;
        @(posedge clk); @(negedge clk);
        mio_en = 1'b0; ld_mdr = 1'b0; r_w = 1'b0;
        e = sb_q.pop_front();
        chk("rw-chg rdata", o_mdr_out, e);
        chk("rw-chg mar", o_mar_out, 16'h0042);
        access(16'h0042, 1'b0, 16'hFFFF, WAITC + 2, "rw-chg no write");

`ifdef LC3_MMIO_EN
        kbd_valid = 1'b1; kbd_char = 8'h41;
        @(negedge clk);
        kbd_valid = 1'b0; kbd_char = 8'h00;
        access(16'hFE00, 1'b0, 16'h8000, 2, "kbsr set");
        access(16'hFE02, 1'b0, 16'h0041, 2, "kbdr");
        access(16'hFE00, 1'b0, 16'h0000, 2, "kbsr clr");
        access(16'hFE04, 1'b0, 16'h8000, 2, "dsr");
        access(16'hFE06, 1'b1, 16'h0021, 2, "ddr write");
        chk("ddr valid at R", dv_at_r, 1);
        chk("ddr valid outside R", dv_outside, 0);
        chk("ddr char", o_disp_char, 8'h21);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
